// File: rtl/button_input_pkg.sv
// button_input_pkg: button indices, default timing and per-channel state shared by button_input.
package button_input_pkg;
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_SELECT = 2;
    localparam int DEF_NUM_BTN        = 3;
    localparam int DEF_TICK_DIV       = 25000;
    localparam int DEF_DEBOUNCE_TICKS = 8;
    localparam int DEF_REPEAT_DELAY   = 400;
    localparam int DEF_REPEAT_RATE    = 50;

    typedef struct packed {
        logic [1:0] sync;
        logic       level;
        logic       level_d;
    } btn_state_t;

    // Counter width for a maximum of n, never zero bits wide.
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel - synchroniser, tick-driven filter, press/release pulses.
// Extra auto-repeat press pulses are built only when AUTOREPEAT_EN is defined.
module btn_debounce
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);
    localparam int CW = cw(DEBOUNCE_TICKS);

    if (DEBOUNCE_TICKS < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad
        $error("btn_debounce: invalid timing parameters");
    end

    btn_state_t st;
    logic [CW-1:0] cnt;
    logic s, hit;

    assign s = st.sync[1];
    assign level = st.level;

`ifdef AUTOREPEAT_EN
    localparam int RW = cw(REPEAT_DELAY);
    logic [RW-1:0] rcnt;

    // After the first repeat, restart at DELAY-RATE so later repeats come every RATE ticks.
    assign hit = tick && st.level && rcnt == RW'(REPEAT_DELAY - 1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            rcnt <= '0;
        else if (!en || !st.level)
            rcnt <= '0;
        else if (tick)
            rcnt <= hit ? RW'(REPEAT_DELAY - REPEAT_RATE) : rcnt + 1'b1;
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            st       <= '0;
            cnt      <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            st.sync    <= {st.sync[0], raw};
            st.level_d <= st.level;
            pressed    <= en && ((st.level && !st.level_d) || hit);
            released   <= en && !st.level && st.level_d;
            if (!en || (tick && s == st.level)) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
                    st.level <= s;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/button_input.sv
// button_input: debounces NUM_BTN raw push-buttons against one shared debounce tick.
// Optional auto-repeat on held buttons via the AUTOREPEAT_EN macro.
module button_input
    import button_input_pkg::*;
#(
    parameter int NUM_BTN        = DEF_NUM_BTN,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    localparam int TW = cw(TICK_DIV);

    if (TICK_DIV < 2) begin : g_bad
        $error("button_input: TICK_DIV must be at least 2");
    end

    logic [TW-1:0] tcnt;
    logic tick;

    assign tick = en && tcnt == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            tcnt <= '0;
        else
            tcnt <= (!en || tick) ? '0 : tcnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
        ) u_btn (
            .clk     (clk),
            .nRst    (nRst),
            .en      (en),
            .tick    (tick),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .pressed (btn_press[i]),
            .released(btn_release[i])
        );
    end
endmodule

// File: tb/tb_button_input.sv
// tb_button_input: directed and random stimulus for button_input, compared every cycle to a tick/run-length model.
module tb_button_input;
    localparam int N  = 3;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic en = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] level, press, rel;

    int checks = 0;
    int errors = 0;

    int ph;
    logic [N-1:0] m_lvl, m_prev, m_press, m_rel;
    int run[N];
    int held[N];
    logic [N-1:0] rq[$];
    int npress[N];
    int nrel[N];

    always #5 clk = ~clk;

    button_input #(
        .NUM_BTN(N), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .nRst(nRst), .en(en), .btn_raw(raw),
        .btn_level(level), .btn_press(press), .btn_release(rel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        m_lvl = '0;
        m_prev = '0;
        m_press = '0;
        m_rel = '0;
        for (int b = 0; b < N; b++) begin
            run[b] = 0;
            held[b] = 0;
        end
        rq = '{3'b000, 3'b000};
    endtask

    // Model of one clock edge using the inputs and state as they were just before it.
    task automatic model_edge();
        logic [N-1:0] s, nl;
        bit tk, fire;
        if (!nRst) begin
            model_reset();
            return;
        end
        s = rq[$-1];
        tk = en && (ph % TD == TD - 1);
        nl = m_lvl;
        for (int b = 0; b < N; b++) begin
            fire = 0;
            if (!en || !m_lvl[b]) held[b] = 0;
            else if (tk) begin
                held[b]++;
`ifdef AUTOREPEAT_EN
                fire = held[b] >= RD && (held[b] - RD) % RR == 0;
`endif
            end
            m_press[b] = en && ((m_lvl[b] && !m_prev[b]) || fire);
            m_rel[b] = en && !m_lvl[b] && m_prev[b];
            if (!en) run[b] = 0;
            else if (tk) begin
                if (s[b] != m_lvl[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        nl[b] = s[b];
                        run[b] = 0;
                    end
                end else run[b] = 0;
            end
        end
        m_prev = m_lvl;
        m_lvl = nl;
        ph = en ? ph + 1 : 0;
        rq.push_back(raw);
        if (rq.size() > 4) void'(rq.pop_front());
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, {23'd0, level, press, rel}, {23'd0, m_lvl, m_press, m_rel});
        for (int b = 0; b < N; b++) begin
            npress[b] += int'(press[b]);
            nrel[b] += int'(rel[b]);
        end
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic clear_counts();
        for (int b = 0; b < N; b++) begin
            npress[b] = 0;
            nrel[b] = 0;
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        nRst = 1'b0;
        #1;
        chk(tag, {23'd0, level, press, rel}, 32'd0);
        model_reset();
        step("in_reset");
    endtask

    initial begin
        int k, n;
        model_reset();
        clear_counts();
        nRst = 1'b0;
        raw = 3'b111;
        steps(3, "reset_hold");
        chk("reset_outputs", {23'd0, level, press, rel}, 32'd0);

        nRst = 1'b1;
        clear_counts();
        steps(18, "t1_rise");
        chk("t1_level", 32'(level), 32'h7);
        steps(4, "t1_tail");
        for (int b = 0; b < N; b++) chk($sformatf("t1_press%0d", b), npress[b], 1);

        raw = 3'b000;
        clear_counts();
        steps(30, "t2_fall");
        chk("t2_all_low", 32'(level), 32'h0);
        for (int b = 0; b < N; b++) chk($sformatf("t2_release%0d", b), nrel[b], 1);
        raw = 3'b001;
        clear_counts();
        steps(8, "t2_glitch");
        raw = 3'b000;
        steps(30, "t2_after");
        chk("t2_glitch_level", 32'(level[0]), 32'h0);
        chk("t2_glitch_press", npress[0] + nrel[0], 0);

        raw = 3'b010;
        clear_counts();
        k = 0;
        while (!level[1] && k < 40) begin
            step("t3_wait");
            k++;
        end
        chk("t3_rise", 32'(level[1]), 32'h1);
        chk("t3_latency_ok", 32'(k >= 11 && k <= 14), 32'h1);
        steps(3, "t3_hold");
        chk("t3_press_width", npress[1], 1);
        raw = 3'b000;
        clear_counts();
        steps(20, "t3_release");
        chk("t3_release_width", nrel[1], 1);
        chk("t3_fall", 32'(level[1]), 32'h0);

        raw = 3'b010;
        clear_counts();
        steps(9, "t4_count");
        chk("t4_mid_level", 32'(level[1]), 32'h0);
        en = 1'b0;
        steps(5, "t4_frozen");
        chk("t4_no_pulse", npress[1] + nrel[1], 0);
        chk("t4_frozen_level", 32'(level[1]), 32'h0);
        en = 1'b1;
        k = 0;
        while (!level[1] && k < 30) begin
            step("t4_restart");
            k++;
        end
        chk("t4_fresh_ticks", k, 12);

        raw = 3'b000;
        steps(6, "t5_pre");
        chk("t5_level_before", 32'(level[1]), 32'h1);
        async_reset("t5_async");
        step("in_reset");

        nRst = 1'b1;
        raw = 3'b100;
        clear_counts();
        steps(60, "t6_hold");
`ifdef AUTOREPEAT_EN
        chk("t6_repeat_count", npress[2], 5);
`else
        chk("t6_single_press", npress[2], 1);
`endif
        chk("t6_others_quiet", npress[0] + npress[1], 0);

        for (int i = 0; i < 250; i++) begin
            raw = N'($urandom_range(0, 7));
            en = ($urandom_range(0, 7) != 0);
            n = $urandom_range(1, 25);
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_async");
                nRst = 1'b1;
            end
            steps(n, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
